// File: rtl/fp_stream_pkg.sv
// Shared definitions for the floating-point stream wrappers: per-format
// latency limits of the IEEE arithmetic units.
package fp_stream_pkg;

  localparam int MaxLatencyH = 5;
  localparam int MaxLatencyS = 6;

  function automatic int max_latency(input int width);
    return (width == 16) ? MaxLatencyH : MaxLatencyS;
  endfunction

endpackage

// File: rtl/IEEESub.sv
// Fixed-latency IEEE-754 subtractor (R = X - Y, round-to-nearest-even) for
// half or single precision; no stall input, result emerges Latency cycles later.
module IEEESub #(
  parameter int DataWidth = 32,
  parameter int Latency   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] X,
  input  logic [DataWidth-1:0] Y,
  output logic [DataWidth-1:0] R
);
  localparam int EW = (DataWidth == 16) ? 5 : 8;
  localparam int MW = DataWidth - EW - 1;
  localparam int SW = MW + 5;  // carry, hidden, mantissa, guard, round, sticky
  localparam logic [EW-1:0] EMax = '1;

  logic [DataWidth-1:0] res_c;
  logic [DataWidth-1:0] pipe_q [Latency];

  logic          sa, sb, sl, ss;
  logic [EW-1:0] ea, eb, el, es, d;
  logic [MW-1:0] ma, mb, ml, ms;
  logic [SW-1:0] sig_l, sig_s, sh, sum;
  logic [EW+1:0] e;
  logic [MW+1:0] mant;
  logic          inc, a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    // Subtraction is addition with the subtrahend sign flipped.
    sa = X[DataWidth-1];
    ea = X[DataWidth-2:MW];
    ma = X[MW-1:0];
    sb = ~Y[DataWidth-1];
    eb = Y[DataWidth-2:MW];
    mb = Y[MW-1:0];
    a_nan = (ea == EMax) && (ma != '0);
    b_nan = (eb == EMax) && (mb != '0);
    a_inf = (ea == EMax) && (ma == '0);
    b_inf = (eb == EMax) && (mb == '0);
    if ({eb, mb} > {ea, ma}) begin
      sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
    end else begin
      sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
    end
    sig_l = {1'b0, el != '0, ml, 3'b000};
    sig_s = {1'b0, es != '0, ms, 3'b000};
    d = ((el == '0) ? EW'(1) : el) - ((es == '0) ? EW'(1) : es);
    if (int'(d) >= SW) sh = {{(SW-1){1'b0}}, |sig_s};
    else sh = (sig_s >> d) | {{(SW-1){1'b0}}, |(sig_s & ~({SW{1'b1}} << d))};
    sum = (sl == ss) ? sig_l + sh : sig_l - sh;
    e = {2'b00, (el == '0) ? EW'(1) : el};
    if (sum[SW-1]) begin
      sum = {1'b0, sum[SW-1:2], sum[1] | sum[0]};
      e = e + (EW+2)'(1);
    end
    // Normalise left, stopping at the subnormal boundary.
    for (int i = 0; i < SW; i++) begin
      if (!sum[SW-2] && e > (EW+2)'(1)) begin
        sum = sum << 1;
        e = e - (EW+2)'(1);
      end
    end
    inc = sum[2] & (sum[1] | sum[0] | sum[3]);
    mant = {1'b0, sum[SW-2:3]} + {{(MW+1){1'b0}}, inc};
    if (mant[MW+1]) begin
      mant = mant >> 1;
      e = e + (EW+2)'(1);
    end
    res_c = {sl, mant[MW] ? e[EW-1:0] : {EW{1'b0}}, mant[MW-1:0]};
    if (mant[MW] && e >= {2'b00, EMax}) res_c = {sl, EMax, {MW{1'b0}}};
    if (mant == '0) res_c = {sl & ss, {(DataWidth-1){1'b0}}};
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      res_c = {1'b0, EMax, 1'b1, {(MW-1){1'b0}}};
    else if (a_inf) res_c = {sa, EMax, {MW{1'b0}}};
    else if (b_inf) res_c = {sb, EMax, {MW{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Latency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= res_c;
      for (int i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign R = pipe_q[Latency-1];

endmodule

// File: rtl/fp_result_fifo.sv
// Generic circular-buffer FIFO; simultaneous push and pop are accepted at any
// fill level, including full.
module fp_result_fifo #(
  parameter type data_t = logic [7:0],
  parameter int  Depth  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  data_t                      push_data,
  input  logic                       pop,
  output data_t                      pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  data_t           mem_q [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[head_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= ptr_next(tail_q);
      if (do_pop)  head_q <= ptr_next(head_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/fp_sub_stream.sv
// Valid/ready wrapper around the stall-free IEEESub pipeline; credits reserve a
// result FIFO slot at admission so backpressure never drops a result.
module fp_sub_stream
  import fp_stream_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Latency   = 3,
  parameter int FifoDepth = 4,
  parameter int TagWidth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] operand_a_i,
  input  logic [DataWidth-1:0] operand_b_i,
  input  logic [TagWidth-1:0]  tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] result_o,
  output logic [TagWidth-1:0]  out_tag_o,
  output logic                 busy_o
);
  localparam int CntW = $clog2(FifoDepth + 1);

  if (FifoDepth < Latency + 1) begin : g_depth_check
    $error("fp_sub_stream: FifoDepth must be >= Latency+1");
  end
  if (DataWidth != 16 && DataWidth != 32) begin : g_width_check
    $error("fp_sub_stream: DataWidth must be 16 or 32");
  end
  if (Latency < 1 || Latency > max_latency(DataWidth)) begin : g_latency_check
    $error("fp_sub_stream: Latency out of range for DataWidth");
  end

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [TagWidth-1:0]  tag;
  } result_t;

  logic [Latency-1:0]   vld_q;
  logic [TagWidth-1:0]  tag_q [Latency];
  logic [CntW-1:0]      inflight_q, fifo_count;
  logic [CntW:0]        occupancy;
  logic                 accept, retire, pop, fifo_full, fifo_empty;
  logic [DataWidth-1:0] sub_r;
  result_t              push_data, head;

  // Both sides: a transfer happens on a rising clock edge where valid and
  // ready are both high; in_ready_o depends only on registered occupancy.
  assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign in_ready_o = (occupancy < (CntW+1)'(FifoDepth));
  assign accept     = in_valid_i & in_ready_o;
  assign retire     = vld_q[Latency-1];
  assign pop        = out_valid_o & out_ready_i;
  assign busy_o     = (occupancy != '0);

  IEEESub #(
    .DataWidth(DataWidth),
    .Latency  (Latency)
  ) u_sub (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .X    (operand_a_i),
    .Y    (operand_b_i),
    .R    (sub_r)
  );

  // Valid and tag travel alongside the subtractor pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < Latency; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= tag_i;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      inflight_q <= inflight_q + CntW'(accept) - CntW'(retire);
    end
  end

  assign push_data = '{data: sub_r, tag: tag_q[Latency-1]};

  fp_result_fifo #(
    .data_t(result_t),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (retire),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid_o = ~fifo_empty;
  assign result_o    = head.data;
  assign out_tag_o   = head.tag;

  assert property (@(posedge clk_i) disable iff (!rst_ni) retire |-> !fifo_full)
    else $error("fp_sub_stream: result FIFO full on retire");

endmodule
